// File: rtl/dot_pkg.sv
// Shared types and width helpers for the dot-product MAC.
package dot_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int calc_beats(input int vec_len, input int lanes);
        return vec_len / lanes;
    endfunction

    // Full-precision accumulator: product width plus growth over the vector plus a guard bit.
    function automatic int calc_accw(input int width, input int vec_len);
        return 2 * width + clog2(vec_len) + 1;
    endfunction

endpackage

// File: rtl/dot_product_mac_if.sv
// Input beat stream and result handshake of the dot-product MAC.
interface dot_product_mac_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*WIDTH-1:0]   in_a;
    logic [LANES*WIDTH-1:0]   in_b;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     out_ovf;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/dot_lane_mult.sv
// LANES parallel signed multipliers summed into one full-precision beat sum (combinational).
module dot_lane_mult
    import dot_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 2,
    localparam int PW   = 2 * WIDTH,
    localparam int SW   = PW + clog2(LANES)
) (
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    output logic signed [SW-1:0]   sum
);

    logic signed [PW-1:0] prod [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign prod[i] = PW'($signed(a[i*WIDTH +: WIDTH])) * PW'($signed(b[i*WIDTH +: WIDTH]));
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum = sum + SW'(prod[i]);
        end
    end

endmodule

// File: rtl/dot_product_mac.sv
// Streaming fixed-point dot product: beat product register, accumulator, rescale and result register.
// Define DOT_SAT_EN to saturate the rescaled result (and flag out_ovf) instead of wrapping.
module dot_product_mac
    import dot_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int FRAC    = 8,
    parameter int LANES   = 2,
    parameter int VEC_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dot_product_mac_if.slave  bus
);

    localparam int BEATS = calc_beats(VEC_LEN, LANES);
    localparam int PW    = 2 * WIDTH;
    localparam int SW    = PW + clog2(LANES);
    localparam int ACCW  = calc_accw(WIDTH, VEC_LEN);
    localparam int CW    = (BEATS > 1) ? clog2(BEATS) : 1;

    state_t                  state, state_next;
    logic [CW-1:0]           cnt;
    logic                    s1_valid;
    logic signed [SW-1:0]    lane_sum;
    logic signed [ACCW-1:0]  s1_sum;
    logic signed [ACCW-1:0]  acc;
    logic [WIDTH-1:0]        data_q, res_data;
    logic                    ovf_q, res_ovf;
    logic                    in_fire, out_fire, last_beat, load_result;

    dot_lane_mult #(.WIDTH(WIDTH), .LANES(LANES)) u_lane_mult (
        .a   (bus.in_a),
        .b   (bus.in_b),
        .sum (lane_sum)
    );

    assign last_beat = (cnt == CW'(BEATS - 1));
    assign in_fire   = bus.in_valid && (state == ACCUM);
    assign out_fire  = bus.out_ready && (state == HOLD);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_next;
    end

    // DRAIN waits while the last product is still in stage 1, then loads the result from the settled acc.
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        load_result   = 1'b0;
        case (state)
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && last_beat) state_next = DRAIN;
            end
            DRAIN: begin
                if (!s1_valid) begin
                    load_result = 1'b1;
                    state_next  = HOLD;
                end
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

`ifdef DOT_SAT_EN
    logic signed [ACCW-1:0] shifted;
    localparam logic signed [ACCW-1:0] MAX_V = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MIN_V = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    always_comb begin
        shifted  = acc >>> FRAC;
        res_data = shifted[WIDTH-1:0];
        res_ovf  = 1'b0;
        if (shifted > MAX_V) begin
            res_data = {1'b0, {(WIDTH-1){1'b1}}};
            res_ovf  = 1'b1;
        end else if (shifted < MIN_V) begin
            res_data = {1'b1, {(WIDTH-1){1'b0}}};
            res_ovf  = 1'b1;
        end
    end
`else
    always_comb begin
        res_data = WIDTH'(acc >>> FRAC);
        res_ovf  = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            acc      <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_sum <= ACCW'(lane_sum);
                cnt    <= last_beat ? '0 : cnt + 1'b1;
            end
            if (s1_valid) acc <= acc + s1_sum;
            if (load_result) begin
                data_q <= res_data;
                ovf_q  <= res_ovf;
            end
            // Handshake starts the next vector from a clean accumulator.
            if (out_fire) begin
                acc      <= '0;
                cnt      <= '0;
                s1_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data = data_q;
    assign bus.out_ovf  = ovf_q;

endmodule

// File: tb/tb_dot_product_mac.sv
// Scoreboard bench for dot_product_mac: directed vectors, expected results queued at issue time.
module tb_dot_product_mac;

    typedef struct packed {
        logic [15:0] data;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    dot_product_mac_if #(.WIDTH(16), .LANES(2)) bus ();

    dot_product_mac #(.WIDTH(16), .FRAC(8), .LANES(2), .VEC_LEN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every output handshake is compared against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h expected none", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 32'(bus.out_data), 32'(e.data));
                check("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
            end
        end
    end

    task automatic push_exp(input logic [15:0] d, input logic o);
        exp_t e;
        e.data = d;
        e.ovf  = o;
        exp_q.push_back(e);
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, output int waited);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        waited       = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic send_vector(input logic [63:0] a, input logic [63:0] b, input int gap,
                               output int first_wait);
        int w;
        first_wait = 0;
        for (int j = 0; j < 2; j++) begin
            send_beat(a[32*j +: 32], b[32*j +: 32], w);
            if (j == 0) first_wait = w;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: got 0 expected 1");
        end
    endtask

    task automatic run_vec(input logic [63:0] a, input logic [63:0] b, input int gap,
                           input logic [15:0] d, input logic o);
        int fw;
        push_exp(d, o);
        send_vector(a, b, gap, fw);
        wait_out_valid();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] A1 = 64'h0400_0300_0200_0100;
    localparam logic [63:0] B1 = 64'h0100_0100_0100_0100;
    localparam logic [63:0] A2 = 64'h0000_0000_0200_FE80;
    localparam logic [63:0] B2 = 64'h0000_0000_0080_0200;
    localparam logic [63:0] A3 = 64'h7FFF_7FFF_7FFF_7FFF;
    localparam logic [63:0] A4 = 64'h0000_0000_0000_0001;
    localparam logic [63:0] B4 = 64'h0000_0000_0000_FFFF;
    localparam logic [63:0] A5 = 64'h8000_8000_8000_8000;

`ifdef DOT_SAT_EN
    localparam logic [15:0] EXP3_D = 16'h7FFF;
    localparam logic        EXP3_O = 1'b1;
    localparam logic [15:0] EXP5_D = 16'h8000;
    localparam logic        EXP5_O = 1'b1;
`else
    localparam logic [15:0] EXP3_D = 16'hFC00;
    localparam logic        EXP3_O = 1'b0;
    localparam logic [15:0] EXP5_D = 16'h0200;
    localparam logic        EXP5_O = 1'b0;
`endif

    initial begin
        int fw;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_data", 32'(bus.out_data), 32'd0);
        check("reset_out_ovf", 32'(bus.out_ovf), 32'd0);
        @(posedge clk);
        #1;

        // Basic vector with latency profile: valid appears after the second edge past the last beat.
        push_exp(16'h0A00, 1'b0);
        send_vector(A1, B1, 0, fw);
        @(negedge clk);
        check("latency_k1", 32'(bus.out_valid), 32'd0);
        check("drain_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("latency_k2", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("latency_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_handshake_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        run_vec(A2, B2, 0, 16'hFE00, 1'b0);
        run_vec(A4, B4, 0, 16'hFFFF, 1'b0);
        run_vec(A3, A3, 0, EXP3_D, EXP3_O);
        run_vec(A5, A3, 0, EXP5_D, EXP5_O);

        // Backpressure: result held stable, then the next vector follows the handshake directly.
        bus.out_ready = 1'b0;
        push_exp(16'h0A00, 1'b0);
        send_vector(A1, B1, 0, fw);
        wait_out_valid();
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_out_data", 32'(bus.out_data), 32'h0A00);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        push_exp(16'hFE00, 1'b0);
        send_vector(A2, B2, 0, fw);
        check("first_beat_wait", 32'(fw), 32'd1);
        wait_out_valid();
        @(posedge clk);
        #1;

        // Reset after one beat: no residue from the aborted vector.
        send_beat(A2[31:0], B2[31:0], fw);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        run_vec(A1, B1, 0, 16'h0A00, 1'b0);

        // Reset while holding a result drops it.
        bus.out_ready = 1'b0;
        push_exp(16'hFE00, 1'b0);
        send_vector(A2, B2, 0, fw);
        wait_out_valid();
        @(posedge clk);
        #1 rst_n = 1'b0;
        void'(exp_q.pop_back());
        repeat (2) @(posedge clk);
        #1 begin
            rst_n = 1'b1;
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        check("holdreset_out_valid", 32'(bus.out_valid), 32'd0);
        check("holdreset_out_data", 32'(bus.out_data), 32'd0);
        @(posedge clk);
        #1;

        // Bubbles between beats give the same results.
        run_vec(A1, B1, 1, 16'h0A00, 1'b0);
        run_vec(A2, B2, 2, 16'hFE00, 1'b0);

        repeat (5) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
